// File: rtl/fc_pkg.sv
// fc_pkg: shared constants for the fully-connected layer engine.
// Holds the FSM state encoding, default Q-format parameters and the
// saturation-limit helpers used by the MAC datapath.
package fc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_IFMAP,
    S_MAC,
    S_BIAS,
    S_WRITE,
    S_DONE
  } state_t;

  // Default Q16.16 signed fixed-point format.
  localparam int FC_DATA_WIDTH = 32;
  localparam int FC_FRAC_BITS  = 16;

  // Limits are returned wide so any accumulator extension can be cut from them.
  localparam int FC_LIMIT_W = 128;

  function automatic logic signed [FC_LIMIT_W-1:0] sat_max(input int w);
    logic signed [FC_LIMIT_W-1:0] one;
    one = FC_LIMIT_W'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic logic signed [FC_LIMIT_W-1:0] sat_min(input int w);
    logic signed [FC_LIMIT_W-1:0] one;
    one = FC_LIMIT_W'(1);
    return -(one <<< (w - 1));
  endfunction

endpackage

// File: rtl/fc_mac.sv
// fc_mac: signed fixed-point multiply, shift, saturating accumulate, bias add, ReLU.
// Latency: accumulator updates on the edge of mac_en/bias_en; result is combinational from it.
// Backpressure: none, the caller strobes mac_en/bias_en only when an operand is present.
// Ports: clk/srstn; clr zeroes the accumulator; mac_en adds (mac_a*mac_b)>>>FRAC_BITS;
//        bias_en adds bias; relu_en masks negative results; result is the neuron output.
module fc_mac
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int FRAC_BITS  = FC_FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         srstn,
  input  logic                         clr,
  input  logic                         mac_en,
  input  logic signed [DATA_WIDTH-1:0] mac_a,
  input  logic signed [DATA_WIDTH-1:0] mac_b,
  input  logic                         bias_en,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic                         relu_en,
  output logic        [DATA_WIDTH-1:0] result
);

  localparam int PW = 2 * DATA_WIDTH;
  // One extra bit over the product so acc + shifted product cannot wrap.
  localparam int EW = PW + 1;
  localparam logic signed [EW-1:0] ACC_MAX = EW'(sat_max(DATA_WIDTH));
  localparam logic signed [EW-1:0] ACC_MIN = EW'(sat_min(DATA_WIDTH));

  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         prod_sh;
  logic signed [EW-1:0]         addend;
  logic signed [EW-1:0]         sum;
  logic signed [DATA_WIDTH-1:0] sum_sat;

  always_comb begin
    prod    = PW'(mac_a) * PW'(mac_b);
    prod_sh = prod >>> FRAC_BITS;
    addend  = bias_en ? EW'(bias) : EW'(prod_sh);
    sum     = EW'(acc) + addend;
    if (sum > ACC_MAX) begin
      sum_sat = ACC_MAX[DATA_WIDTH-1:0];
    end else if (sum < ACC_MIN) begin
      sum_sat = ACC_MIN[DATA_WIDTH-1:0];
    end else begin
      sum_sat = sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn || clr) begin
      acc <= '0;
    end else if (mac_en || bias_en) begin
      acc <= sum_sat;
    end
  end

  // ReLU only masks the output; the accumulator keeps its signed value.
  assign result = (relu_en && acc[DATA_WIDTH-1]) ? '0 : acc;

endmodule

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: fully-connected layer, loads ifmap once then per neuron MACs weights, adds bias, writes.
// Latency: one read in flight; each word costs one cycle plus read latency; one write per neuron.
// Backpressure: rd_valid paces reads; wr_en/wr_addr/wr_data hold until wr_ready.
// Ports: start + cfg_* (latched at start in IDLE); rd_req/rd_addr -> rd_valid/rd_data read port;
//        wr_en/wr_addr/wr_data <- wr_ready write port; busy, done pulse, err pulse with done.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int FRAC_BITS  = 16,
  parameter int MAX_IN     = 400,
  parameter int MAX_OUT    = 120
) (
  input  logic                           clk,
  input  logic                           srstn,
  input  logic                           start,
  input  logic [$clog2(MAX_IN+1)-1:0]    cfg_num_in,
  input  logic [$clog2(MAX_OUT+1)-1:0]   cfg_num_out,
  input  logic                           cfg_relu_en,
  input  logic [ADDR_WIDTH-1:0]          cfg_ifmap_base,
  input  logic [ADDR_WIDTH-1:0]          cfg_wt_base,
  input  logic [ADDR_WIDTH-1:0]          cfg_bs_base,
  input  logic [ADDR_WIDTH-1:0]          cfg_ofmap_base,
  output logic                           rd_req,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic                           rd_valid,
  input  logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           wr_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int NI_W = $clog2(MAX_IN + 1);
  localparam int NO_W = $clog2(MAX_OUT + 1);
  localparam int BI_W = $clog2(MAX_IN);
  localparam int AW   = ADDR_WIDTH;

  state_t state, state_nx;

  logic [NI_W-1:0]       n_in, idx, cnt_nx;
  logic [NO_W-1:0]       n_out, k;
  logic                  relu;
  logic [AW-1:0]         if_base, bs_base, of_base, wt_ptr;
  logic                  pend, err_q;
  logic                  got, last, cfg_bad;
  logic                  issue, clr, mac_en, bias_en;
  logic [AW-1:0]         issue_addr;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] ifbuf [MAX_IN];

  // A return only counts while a read is outstanding; stray rd_valid is dropped.
  assign got     = pend && rd_valid;
  assign cnt_nx  = got ? idx + NI_W'(1) : idx;
  assign last    = got && (cnt_nx == n_in);
  assign cfg_bad = (cfg_num_in == '0) || (cfg_num_in > NI_W'(MAX_IN)) ||
                   (cfg_num_out == '0) || (cfg_num_out > NO_W'(MAX_OUT));

  // Next read may issue on the very cycle the previous one returns.
  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    issue_addr = '0;
    clr        = 1'b0;
    mac_en     = 1'b0;
    bias_en    = 1'b0;
    case (state)
      S_IDLE: begin
        clr = 1'b1;
        if (start) state_nx = cfg_bad ? S_DONE : S_LD_IFMAP;
      end
      S_LD_IFMAP: begin
        issue      = (!pend || got) && (cnt_nx < n_in);
        issue_addr = if_base + AW'(cnt_nx);
        if (last) state_nx = S_MAC;
      end
      S_MAC: begin
        mac_en     = got;
        issue      = (!pend || got) && (cnt_nx < n_in);
        issue_addr = wt_ptr + AW'(cnt_nx);
        if (last) state_nx = S_BIAS;
      end
      S_BIAS: begin
        bias_en    = got;
        issue      = !pend;
        issue_addr = bs_base + AW'(k);
        if (got) state_nx = S_WRITE;
      end
      S_WRITE: begin
        if (wr_ready) begin
          if ((k + NO_W'(1)) == n_out) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_MAC;
            clr      = 1'b1;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state   <= S_IDLE;
      rd_req  <= 1'b0;
      rd_addr <= '0;
      pend    <= 1'b0;
      idx     <= '0;
      k       <= '0;
      n_in    <= '0;
      n_out   <= '0;
      relu    <= 1'b0;
      if_base <= '0;
      bs_base <= '0;
      of_base <= '0;
      wt_ptr  <= '0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      rd_req <= issue;
      if (issue) begin
        rd_addr <= issue_addr;
        pend    <= 1'b1;
      end else if (got) begin
        pend    <= 1'b0;
      end
      if (state == S_LD_IFMAP || state == S_MAC) begin
        idx <= last ? '0 : cnt_nx;
      end
      if (state == S_IDLE && start) begin
        n_in    <= cfg_num_in;
        n_out   <= cfg_num_out;
        relu    <= cfg_relu_en;
        if_base <= cfg_ifmap_base;
        bs_base <= cfg_bs_base;
        of_base <= cfg_ofmap_base;
        wt_ptr  <= cfg_wt_base;
        err_q   <= cfg_bad;
        k       <= '0;
        idx     <= '0;
      end
      // Weights are contiguous per neuron, so the row base steps by n_in.
      if (state == S_WRITE && wr_ready) begin
        k      <= k + NO_W'(1);
        wt_ptr <= wt_ptr + AW'(n_in);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LD_IFMAP && got) ifbuf[idx[BI_W-1:0]] <= rd_data;
  end

  fc_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .clk     (clk),
    .srstn   (srstn),
    .clr     (clr),
    .mac_en  (mac_en),
    .mac_a   (ifbuf[idx[BI_W-1:0]]),
    .mac_b   (rd_data),
    .bias_en (bias_en),
    .bias    (rd_data),
    .relu_en (relu),
    .result  (result)
  );

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign err     = done && err_q;
  assign wr_en   = (state == S_WRITE);
  assign wr_addr = wr_en ? of_base + AW'(k) : '0;
  assign wr_data = wr_en ? result : '0;

endmodule

// File: tb/tb_fc_layer_engine.sv
module tb_fc_layer_engine;

  localparam int DW     = 32;
  localparam int AW     = 18;
  localparam int NI_W   = $clog2(401);
  localparam int NO_W   = $clog2(121);
  localparam int BUDGET = 150000;
  localparam logic [AW-1:0] IF_B = 18'h00000;
  localparam logic [AW-1:0] WT_B = 18'h01000;
  localparam logic [AW-1:0] BS_B = 18'h0D000;
  localparam logic [AW-1:0] OF_B = 18'h0E000;

  logic            clk, srstn, start, cfg_relu_en;
  logic [NI_W-1:0] cfg_num_in;
  logic [NO_W-1:0] cfg_num_out;
  logic [AW-1:0]   cfg_ifmap_base, cfg_wt_base, cfg_bs_base, cfg_ofmap_base;
  logic            rd_req, rd_valid, wr_en, wr_ready, busy, done, err;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [DW-1:0]   rd_data, wr_data;

  logic [31:0]     mem [0:65535];
  logic [AW-1:0]   wq_addr [$];
  logic [DW-1:0]   wq_data [$];
  int              n_checks = 0;
  int              n_fail = 0;
  int              rd_cnt = 0;
  int              lat_mode = 0;
  bit              rand_wr = 0;
  bit              hold_mode = 0;

  fc_layer_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAC_BITS(16), .MAX_IN(400), .MAX_OUT(120)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start),
    .cfg_num_in(cfg_num_in), .cfg_num_out(cfg_num_out), .cfg_relu_en(cfg_relu_en),
    .cfg_ifmap_base(cfg_ifmap_base), .cfg_wt_base(cfg_wt_base),
    .cfg_bs_base(cfg_bs_base), .cfg_ofmap_base(cfg_ofmap_base),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read responder: one request at a time, data returned after a latency of 1..N cycles.
  initial begin : responder
    logic [AW-1:0] a;
    int pcnt;
    rd_valid = 1'b0;
    rd_data  = '0;
    pcnt     = 0;
    a        = '0;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      if (rd_req) begin
        rd_cnt++;
        check("rd_overlap", 64'(pcnt), 64'd0);
        if (pcnt == 0) begin
          a = rd_addr;
          if (lat_mode == 2) pcnt = 6;
          else if (lat_mode == 1 && $urandom_range(0, 15) == 0) pcnt = $urandom_range(1, 4);
          else pcnt = 1;
        end
      end
      if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = mem[a[15:0]];
        end
      end
    end
  end

  // Write acceptor: optional 5-cycle stall with stability checks, else random/always ready.
  initial begin : writer
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    int hold_cnt;
    hold_cnt = 0;
    h_addr   = '0;
    h_data   = '0;
    wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_mode && (wr_en || hold_cnt > 0) && hold_cnt < 5) begin
        if (hold_cnt == 0) begin
          h_addr = wr_addr;
          h_data = wr_data;
        end else begin
          check("hold_wr_en", 64'(wr_en), 64'd1);
          check("hold_wr_addr", 64'(wr_addr), 64'(h_addr));
          check("hold_wr_data", 64'(wr_data), 64'(h_data));
        end
        hold_cnt++;
        wr_ready = 1'b0;
      end else begin
        wr_ready = rand_wr ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (wr_en && wr_ready && srstn) begin
          wq_addr.push_back(wr_addr);
          wq_data.push_back(wr_data);
          hold_cnt = 0;
        end
      end
    end
  end

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [31:0] ref_neuron(input int kk, input int ni, input bit relu);
    longint acc, p;
    acc = 0;
    for (int i = 0; i < ni; i++) begin
      p   = (longint'($signed(mem[int'(IF_B) + i])) *
             longint'($signed(mem[int'(WT_B) + kk * ni + i]))) >>> 16;
      acc = sat32(acc + p);
    end
    acc = sat32(acc + longint'($signed(mem[int'(BS_B) + kk])));
    if (relu && acc < 0) acc = 0;
    return acc[31:0];
  endfunction

  task automatic fill(input int ni, input int no, input logic [31:0] x, w, b);
    for (int i = 0; i < ni; i++) mem[int'(IF_B) + i] = x;
    for (int j = 0; j < ni * no; j++) mem[int'(WT_B) + j] = w;
    for (int kk = 0; kk < no; kk++) mem[int'(BS_B) + kk] = b;
  endtask

  task automatic drive_cfg(input int ni, input int no, input bit relu);
    cfg_num_in     = NI_W'(ni);
    cfg_num_out    = NO_W'(no);
    cfg_relu_en    = relu;
    cfg_ifmap_base = IF_B;
    cfg_wt_base    = WT_B;
    cfg_bs_base    = BS_B;
    cfg_ofmap_base = OF_B;
  endtask

  task automatic run_cfg(input string tag, input int ni, input int no, input bit relu,
                         output int ncyc, output bit got_err);
    bit seen;
    seen    = 0;
    got_err = 0;
    ncyc    = 0;
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    rd_cnt = 0;
    drive_cfg(ni, no, relu);
    start = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      start = 1'b0;
      ncyc++;
      if (c == 0) check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
      if (done) begin
        seen    = 1;
        got_err = err;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    check({tag, "_busy_after_done"}, 64'(busy), 64'd0);
  endtask

  task automatic check_uniform(input string tag, input int ni, input int no,
                               input logic [31:0] exp);
    check({tag, "_wr_count"}, 64'(wq_data.size()), 64'(no));
    check({tag, "_rd_count"}, 64'(rd_cnt), 64'(ni + no * (ni + 1)));
    for (int kk = 0; kk < no && kk < wq_data.size(); kk++) begin
      check({tag, "_wr_addr"}, 64'(wq_addr[kk]), 64'(OF_B + AW'(kk)));
      check({tag, "_wr_data"}, 64'(wq_data[kk]), 64'(exp));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  typedef struct {
    string       name;
    int          ni;
    int          no;
    bit          relu;
    logic [31:0] x;
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] exp_big [120];
  int          ncyc;
  bit          got_err;
  bit          reached;

  initial begin
    vecs[0]  = '{"q_basic",     4,   2,   1'b0, 32'h00010000, 32'h00008000, 32'h00004000, 32'h00024000, 1'b0};
    vecs[1]  = '{"relu_on",     1,   1,   1'b1, 32'h00010000, 32'hFFFF0000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[2]  = '{"relu_off",    1,   1,   1'b0, 32'h00010000, 32'hFFFF0000, 32'h00000000, 32'hFFFF0000, 1'b0};
    vecs[3]  = '{"sat_pos",     2,   1,   1'b0, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0};
    vecs[4]  = '{"sat_neg",     2,   1,   1'b0, 32'h7FFF0000, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0};
    vecs[5]  = '{"floor_shift", 3,   2,   1'b0, 32'hFFFFFFFF, 32'h00008000, 32'h00000005, 32'h00000002, 1'b0};
    vecs[6]  = '{"max_in",      400, 1,   1'b0, 32'h00000100, 32'h00000100, 32'h00000000, 32'h00000190, 1'b0};
    vecs[7]  = '{"max_out",     1,   120, 1'b1, 32'h00020000, 32'h00018000, 32'hFFFF8000, 32'h00028000, 1'b0};
    vecs[8]  = '{"err_in0",     0,   1,   1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[9]  = '{"err_out0",    1,   0,   1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[10] = '{"err_in_big",  401, 1,   1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{"err_out_big", 1,   121, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};

    srstn = 1'b0;
    start = 1'b0;
    drive_cfg(0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    srstn = 1'b1;

    for (int v = 0; v < 12; v++) begin
      fill(vecs[v].ni, vecs[v].no, vecs[v].x, vecs[v].w, vecs[v].b);
      run_cfg(vecs[v].name, vecs[v].ni, vecs[v].no, vecs[v].relu, ncyc, got_err);
      check({vecs[v].name, "_err"}, 64'(got_err), 64'(vecs[v].exp_err));
      if (vecs[v].exp_err) begin
        check({vecs[v].name, "_done_latency"}, 64'(ncyc), 64'd1);
        check({vecs[v].name, "_no_reads"}, 64'(rd_cnt), 64'd0);
        check({vecs[v].name, "_no_writes"}, 64'(wq_data.size()), 64'd0);
      end else begin
        check_uniform(vecs[v].name, vecs[v].ni, vecs[v].no, vecs[v].exp);
      end
    end

    // Write stalled for 5 cycles on every neuron.
    hold_mode = 1;
    fill(4, 2, 32'h00010000, 32'h00008000, 32'h00004000);
    run_cfg("hold", 4, 2, 1'b0, ncyc, got_err);
    check("hold_err", 64'(got_err), 64'd0);
    check_uniform("hold", 4, 2, 32'h00024000);
    hold_mode = 0;

    // Reset in the middle of MAC with a read still in flight.
    lat_mode = 2;
    @(negedge clk);
    rd_cnt = 0;
    drive_cfg(4, 2, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reached = 0;
    for (int c = 0; c < 500; c++) begin
      if (rd_cnt >= 6) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_mac", 64'(reached), 64'd1);
    srstn = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    srstn = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_rd_req", 64'(rd_req), 64'd0);
    lat_mode = 0;
    run_cfg("after_reset", 4, 2, 1'b0, ncyc, got_err);
    check("after_reset_err", 64'(got_err), 64'd0);
    check_uniform("after_reset", 4, 2, 32'h00024000);

    // Full-size layer, jittered read latency and random write acceptance.
    lat_mode = 1;
    rand_wr  = 1;
    for (int i = 0; i < 400; i++) mem[int'(IF_B) + i] = 32'(int'($urandom_range(0, 262143)) - 131072);
    for (int j = 0; j < 48000; j++) mem[int'(WT_B) + j] = 32'(int'($urandom_range(0, 262143)) - 131072);
    for (int kk = 0; kk < 120; kk++) begin
      if (kk % 10 == 3) mem[int'(BS_B) + kk] = 32'h7FFFFFF0;
      else if (kk % 10 == 7) mem[int'(BS_B) + kk] = 32'h80000010;
      else mem[int'(BS_B) + kk] = 32'(int'($urandom_range(0, 2097151)) - 1048576);
    end
    for (int kk = 0; kk < 120; kk++) exp_big[kk] = ref_neuron(kk, 400, 1'b0);
    run_cfg("big", 400, 120, 1'b0, ncyc, got_err);
    check("big_err", 64'(got_err), 64'd0);
    check("big_wr_count", 64'(wq_data.size()), 64'd120);
    check("big_rd_count", 64'(rd_cnt), 64'd48520);
    for (int kk = 0; kk < 120 && kk < wq_data.size(); kk++) begin
      check("big_wr_addr", 64'(wq_addr[kk]), 64'(OF_B + AW'(kk)));
      check("big_wr_data", 64'(wq_data[kk]), 64'(exp_big[kk]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
